// File: rtl/mw_lsu_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mw_lsu_writeback_pkg
// Purpose  : Shared funct3 codes, writeback selects and LSU state encoding
// Revision : 1.0
// ============================================================================
package mw_lsu_writeback_pkg;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } lsu_state_e;

endpackage : mw_lsu_writeback_pkg
`default_nettype wire

// File: rtl/mw_lsu_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : mw_lsu_writeback_if
// Purpose  : Data-memory req/ack bus between the LSU (master) and memory
// Revision : 1.0
// ============================================================================
interface mw_lsu_writeback_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack
    );
endinterface : mw_lsu_writeback_if
`default_nettype wire

// File: rtl/mw_lsu_writeback_align.sv
`default_nettype none
// ============================================================================
// Module   : mw_lsu_writeback_align
// Purpose  : Byte-lane steering for stores and sign/zero extraction for loads
// Revision : 1.0
// ============================================================================
module mw_lsu_writeback_align
    import mw_lsu_writeback_pkg::*;
(
    input  wire logic [2:0]  funct3,
    input  wire logic [1:0]  addr_lo,
    input  wire logic        is_store,
    input  wire logic [31:0] wd,
    input  wire logic [31:0] rdata,
    output logic      [3:0]  be,
    output logic      [31:0] wdata,
    output logic      [31:0] load_data,
    output logic             misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo)
            2'b00:   w_byte = rdata[7:0];
            2'b01:   w_byte = rdata[15:8];
            2'b10:   w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be         = 4'b1111;
        wdata      = wd;
        load_data  = rdata;
        misaligned = 1'b0;
        // funct3[1:0] selects size; 011/110/111 fall through to word access
        case (funct3[1:0])
            2'b00: begin
                if (is_store) begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{wd[7:0]}};
                end
                load_data = funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            2'b01: begin
                misaligned = addr_lo[0];
                if (is_store) begin
                    be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{wd[15:0]}};
                end
                load_data = funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule : mw_lsu_writeback_align
`default_nettype wire

// File: rtl/mw_lsu_writeback.sv
`default_nettype none
// ============================================================================
// Module   : mw_lsu_writeback
// Purpose  : RV32I memory/writeback stage: req/ack load-store, writeback mux
// Revision : 1.0
// ============================================================================
module mw_lsu_writeback
    import mw_lsu_writeback_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] pc_mw,
    input  wire logic [31:0] inst_mw,
    input  wire logic [31:0] alu_mw,
    input  wire logic [31:0] wd_mw,
    input  wire logic [1:0]  wb_sel_mw,
    input  wire logic        reg_wr_mw,
    input  wire logic        wr_en_mw,
    input  wire logic        rd_en_mw,
    mw_lsu_writeback_if.master dmem,
    output logic             stall_o,
    output logic             rf_we,
    output logic      [4:0]  rf_waddr,
    output logic      [31:0] rf_wdata,
    output logic             misalign_err,
    output logic             bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic        w_mem_op;
    logic        w_misaligned;
    logic [31:0] w_load_data;
    logic [4:0]  w_rd;
    logic        w_unused;

    assign w_rd     = inst_mw[11:7];
    assign w_mem_op = rd_en_mw | wr_en_mw;
    assign w_unused = ^{inst_mw[31:15], inst_mw[6:0]};

    mw_lsu_writeback_align u_align (
        .funct3     (inst_mw[14:12]),
        .addr_lo    (alu_mw[1:0]),
        .is_store   (wr_en_mw),
        .wd         (wd_mw),
        .rdata      (dmem.rdata),
        .be         (dmem.be),
        .wdata      (dmem.wdata),
        .load_data  (w_load_data),
        .misaligned (w_misaligned)
    );

    // Attributes track the MW inputs, which the stall keeps frozen during WAIT
    assign dmem.we   = wr_en_mw;
    assign dmem.addr = {alu_mw[31:2], 2'b00};

    always_comb begin
        dmem.req     = 1'b0;
        misalign_err = 1'b0;
        bus_err      = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    dmem.req     = w_mem_op & ~w_misaligned;
                    misalign_err = w_mem_op & w_misaligned;
                end
                ST_WAIT: dmem.req = 1'b1;
                ST_ERR:  bus_err  = 1'b1;
                default: ;
            endcase
        end
    end

    assign stall_o  = dmem.req & ~dmem.ack;
    assign rf_waddr = w_rd;
    assign rf_we    = ~rst & reg_wr_mw & (w_rd != 5'd0) & ~stall_o
                      & ~misalign_err & (r_state != ST_ERR);

    always_comb begin
        case (wb_sel_mw)
            WB_LOAD: rf_wdata = w_load_data;
            WB_PC4:  rf_wdata = pc_mw + 32'd4;
            default: rf_wdata = alu_mw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dmem.req && !dmem.ack) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (dmem.ack) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= ST_ERR;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                ST_ERR: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule : mw_lsu_writeback
`default_nettype wire

// File: tb/tb_mw_lsu_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_mw_lsu_writeback
// Purpose  : Directed self-checking bench for mw_lsu_writeback
// Revision : 1.0
// ============================================================================
module tb_mw_lsu_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_mw, inst_mw, alu_mw, wd_mw;
    logic [1:0]  wb_sel_mw;
    logic        reg_wr_mw, wr_en_mw, rd_en_mw;
    logic        stall_o, rf_we, misalign_err, bus_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    mw_lsu_writeback_if dmem ();

    mw_lsu_writeback #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_mw        (pc_mw),
        .inst_mw      (inst_mw),
        .alu_mw       (alu_mw),
        .wd_mw        (wd_mw),
        .wb_sel_mw    (wb_sel_mw),
        .reg_wr_mw    (reg_wr_mw),
        .wr_en_mw     (wr_en_mw),
        .rd_en_mw     (rd_en_mw),
        .dmem         (dmem.master),
        .stall_o      (stall_o),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd);
        return {17'h0, f3, rd, 7'h03};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_mw = 32'h0; inst_mw = 32'h0; alu_mw = 32'h0; wd_mw = 32'h0;
        wb_sel_mw = 2'b00; reg_wr_mw = 1'b0; wr_en_mw = 1'b0; rd_en_mw = 1'b0;
        dmem.ack = 1'b0; dmem.rdata = 32'h0;
    endtask

    task automatic mem_op(input logic st, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] wd);
        inst_mw = mk_inst(f3, rd); alu_mw = addr; wd_mw = wd;
        wr_en_mw = st; rd_en_mw = ~st; reg_wr_mw = ~st;
        wb_sel_mw = st ? 2'b00 : 2'b01;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        mem_op(1'b0, 3'b010, 5'd3, 32'h200, 32'h0);
        @(negedge clk);
        checks++;
        if (dmem.req !== 1'b0 || stall_o !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b stall=%b rf_we=%b, required 0 0 0", dmem.req, stall_o, rf_we);
        end
        step(); step();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (dmem.req !== 1'b0 || bus_err !== 1'b0 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: req=%b bus_err=%b mis=%b, required 0 0 0", dmem.req, bus_err, misalign_err);
        end
        step();
    endtask

    task automatic test_store_wait();
        int req_cyc = 0, stall_cyc = 0;
        mem_op(1'b1, 3'b010, 5'd0, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (dmem.we !== 1'b1 || dmem.be !== 4'b1111 || dmem.addr !== 32'h100 || dmem.wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_attr: we=%b be=%b addr=%h wdata=%h, required 1 1111 00000100 deadbeef",
                     dmem.we, dmem.be, dmem.addr, dmem.wdata);
        end
        for (int c = 0; c < 3; c++) begin
            dmem.ack = (c == 2);
            #1;
            if (dmem.req === 1'b1) req_cyc++;
            if (stall_o === 1'b1) stall_cyc++;
            checks++;
            if (rf_we !== 1'b0) begin
                errors++;
                $display("FAIL sw_rf_we cycle %0d: got %b, required 0", c, rf_we);
            end
            step();
        end
        checks++;
        if (req_cyc != 3 || stall_cyc != 2) begin
            errors++;
            $display("FAIL sw_wait_counts: req=%0d stall=%0d, required 3 2", req_cyc, stall_cyc);
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (dmem.req !== 1'b0) begin
            errors++;
            $display("FAIL sw_done_idle: req=%b, required 0", dmem.req);
        end
        step();
    endtask

    task automatic test_loads();
        // LB from lane 3, sign-extended, zero-wait
        mem_op(1'b0, 3'b000, 5'd5, 32'h103, 32'h0);
        dmem.rdata = 32'h80FFFF7F; dmem.ack = 1'b1;
        @(negedge clk);
        checks++;
        if (rf_wdata !== 32'hFFFFFF80 || rf_we !== 1'b1 || stall_o !== 1'b0 || rf_waddr !== 5'd5
            || dmem.req !== 1'b1 || dmem.be !== 4'b1111 || dmem.addr !== 32'h100) begin
            errors++;
            $display("FAIL lb: wdata=%h we=%b stall=%b waddr=%0d req=%b be=%b addr=%h, required ffffff80 1 0 5 1 1111 00000100",
                     rf_wdata, rf_we, stall_o, rf_waddr, dmem.req, dmem.be, dmem.addr);
        end
        step();
        mem_op(1'b0, 3'b101, 5'd6, 32'h102, 32'h0);
        dmem.rdata = 32'hBEEF1234;
        @(negedge clk);
        checks++;
        if (rf_wdata !== 32'h0000BEEF || rf_we !== 1'b1) begin
            errors++;
            $display("FAIL lhu: wdata=%h we=%b, required 0000beef 1", rf_wdata, rf_we);
        end
        step();
        mem_op(1'b0, 3'b001, 5'd7, 32'h100, 32'h0);
        dmem.rdata = 32'h12348001;
        @(negedge clk);
        checks++;
        if (rf_wdata !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL lh: wdata=%h, required ffff8001", rf_wdata);
        end
        step();
        mem_op(1'b0, 3'b010, 5'd8, 32'h102, 32'h0);
        @(negedge clk);
        checks++;
        if (misalign_err !== 1'b1 || dmem.req !== 1'b0 || rf_we !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL lw_misalign: mis=%b req=%b we=%b stall=%b, required 1 0 0 0",
                     misalign_err, dmem.req, rf_we, stall_o);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: mis=%b, required 0", misalign_err);
        end
        step();
    endtask

    task automatic test_store_lanes();
        dmem.ack = 1'b1;
        mem_op(1'b1, 3'b000, 5'd0, 32'h101, 32'h123456AB);
        @(negedge clk);
        checks++;
        if (dmem.be !== 4'b0010 || dmem.wdata !== 32'hABABABAB || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL sb: be=%b wdata=%h stall=%b, required 0010 abababab 0", dmem.be, dmem.wdata, stall_o);
        end
        step();
        mem_op(1'b1, 3'b001, 5'd0, 32'h102, 32'h1234CAFE);
        @(negedge clk);
        checks++;
        if (dmem.be !== 4'b1100 || dmem.wdata !== 32'hCAFECAFE) begin
            errors++;
            $display("FAIL sh: be=%b wdata=%h, required 1100 cafecafe", dmem.be, dmem.wdata);
        end
        step();
        mem_op(1'b1, 3'b001, 5'd0, 32'h101, 32'h1234CAFE);
        @(negedge clk);
        checks++;
        if (misalign_err !== 1'b1 || dmem.req !== 1'b0) begin
            errors++;
            $display("FAIL sh_misalign: mis=%b req=%b, required 1 0", misalign_err, dmem.req);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_timeout();
        int req_cyc = 0;
        mem_op(1'b0, 3'b010, 5'd9, 32'h300, 32'h0);
        dmem.ack = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (dmem.req === 1'b1 && stall_o === 1'b1 && bus_err === 1'b0) req_cyc++;
            step();
        end
        checks++;
        if (req_cyc != 16) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d, required 16", req_cyc);
        end
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b1 || dmem.req !== 1'b0 || stall_o !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: bus_err=%b req=%b stall=%b we=%b, required 1 0 0 0",
                     bus_err, dmem.req, stall_o, rf_we);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0 || dmem.req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover: bus_err=%b req=%b, required 0 0", bus_err, dmem.req);
        end
        step();
    endtask

    task automatic test_jal();
        pc_mw = 32'hFFFFFFFC; inst_mw = mk_inst(3'b000, 5'd1);
        wb_sel_mw = 2'b10; reg_wr_mw = 1'b1; alu_mw = 32'h55;
        @(negedge clk);
        checks++;
        if (rf_wdata !== 32'h0 || rf_we !== 1'b1 || rf_waddr !== 5'd1 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL jal_wrap: wdata=%h we=%b waddr=%0d stall=%b, required 00000000 1 1 0",
                     rf_wdata, rf_we, rf_waddr, stall_o);
        end
        step();
        inst_mw = mk_inst(3'b000, 5'd0);
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL jal_rd0: we=%b, required 0", rf_we);
        end
        step();
        inst_mw = mk_inst(3'b000, 5'd4); wb_sel_mw = 2'b00;
        @(negedge clk);
        checks++;
        if (rf_wdata !== 32'h55 || rf_we !== 1'b1) begin
            errors++;
            $display("FAIL alu_wb: wdata=%h we=%b, required 00000055 1", rf_wdata, rf_we);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_rst_in_wait();
        mem_op(1'b0, 3'b010, 5'd10, 32'h400, 32'h0);
        dmem.ack = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dmem.req !== 1'b0 || stall_o !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait: req=%b stall=%b we=%b, required 0 0 0", dmem.req, stall_o, rf_we);
        end
        step();
        rst = 1'b0;
        idle_inputs();
        dmem.ack = 1'b1; dmem.rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (dmem.req !== 1'b0 || rf_we !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: req=%b we=%b stall=%b, required 0 0 0", dmem.req, rf_we, stall_o);
        end
        step();
        dmem.ack = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem.req !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle_after: req=%b bus_err=%b, required 0 0", dmem.req, bus_err);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_store_wait();
        test_loads();
        test_store_lanes();
        test_timeout();
        test_jal();
        test_rst_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mw_lsu_writeback
`default_nettype wire
